cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
Exception/interrupt sequencer between the MEM stage and the CP0 register file. It samples exception flags and the interrupt condition from the MEM-stage instruction and picks the highest-priority event. It waits for outstanding bus transactions to drain, then issues a single commit pulse to CP0 with code, EPC and BadVAddr data. It then flushes the pipeline and holds a PC redirect to IF until IF accepts it.

Parameters:
EXC_VEC_NORMAL, 32'h8000_0180, exception vector when Status.BEV=0
EXC_VEC_BOOT, 32'hBFC0_0380, exception vector when Status.BEV=1

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
mem_valid  in  1  MEM stage holds a valid instruction
mem_pc  in  32  PC of the MEM instruction
mem_delay_slot  in  1  MEM instruction is in a delay slot
mem_vaddr  in  32  data virtual address (ALU result)
exc_flags  in  8  [7]AdEL-IF [6]RI [5]Sys [4]Bp [3]Eret [2]Ov [1]AdES [0]AdEL-MEM
status  in  32  CP0 Status; bits used: [22]BEV, [15:8]IM, [1]EXL, [0]IE
cause_ip  in  8  CP0 Cause[15:8]
epc  in  32  CP0 EPC
bus_busy  in  1  an instruction or data bus transaction is outstanding
cp0_commit  out  1  one-cycle pulse: write exception state to CP0
cp0_eret  out  1  one-cycle pulse: clear Status.EXL
cp0_exc_code  out  5  ExcCode
cp0_epc_we  out  1  EPC and BD update enabled; qualifies cp0_commit
cp0_exc_pc  out  32  EPC value
cp0_bd  out  1  Cause.BD value
cp0_badvaddr_we  out  1  BadVAddr update; qualifies cp0_commit
cp0_badvaddr  out  32  BadVAddr value
flush  out  1  flush IF..MEM and block all writeback
redir_valid  out  1  redirect request to IF
redir_pc  out  32  redirect target
redir_ready  in  1  IF accepts the redirect

Behaviour:
- irq = status[0] & ~status[1] & |(cause_ip & status[15:8]). An interrupt is taken only when mem_valid=1.
- Event detect occurs in IDLE when mem_valid & (irq | |exc_flags). Priority, high to low: Int(0), AdEL-IF(4), RI(10), Sys(8), Bp(9), Eret, Ov(12), AdES(5), AdEL-MEM(4).
- Detect cycle latches the following into registers:
  - code
  - is_eret
  - cp0_exc_pc = mem_delay_slot ? mem_pc-4 : mem_pc, with 32-bit wrap
  - cp0_bd = mem_delay_slot
  - cp0_epc_we = ~status[1]
  - cp0_badvaddr = mem_pc for AdEL-IF, mem_vaddr for AdES/AdEL-MEM
  - cp0_badvaddr_we = 1 only for those three codes
- For an Eret event, both cp0_epc_we and cp0_badvaddr_we are 0.
- FSM states IDLE, DRAIN, COMMIT, REDIR, all registered:
  - IDLE: on detect, go to DRAIN if bus_busy, else to COMMIT.
  - DRAIN: stay while bus_busy=1; go to COMMIT on the first cycle bus_busy=0. There is no timeout.
  - COMMIT: exactly one cycle. Assert cp0_commit (exception) or cp0_eret (eret), never both. redir_pc is latched this cycle: epc for eret (this captures an MTC0 EPC committed earlier), else status[22] ? EXC_VEC_BOOT : EXC_VEC_NORMAL. Next state is REDIR.
  - REDIR: redir_valid=1 with redir_pc stable until redir_ready=1. Return to IDLE the cycle after the handshake.
- Latency from detect with bus idle: COMMIT pulse 1 cycle after detect; redir_valid rises 2 cycles after detect.
- flush = 1 in DRAIN, COMMIT and REDIR; 0 in IDLE.
- No new detection while not in IDLE; MEM inputs are ignored there.
- If redir_ready is already 1 on the first REDIR cycle, REDIR lasts exactly 1 cycle.
- Reset (async, any state): state IDLE; every output 0, including cp0_exc_pc, cp0_badvaddr and redir_pc.

Optional Feature:
CP0_EXC_STAT_EN
- Defined: extra outputs exc_count[31:0] and eret_count[31:0].
  - exc_count increments on each cp0_commit; eret_count increments on each cp0_eret.
  - Both wrap at 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Sys at mem_pc=0xBFC0_0100, not delay slot, bus idle, status=0 -> cp0_commit 1 cycle later with code=8, exc_pc=0xBFC0_0100, bd=0, epc_we=1; redir_pc=0x8000_0180 while BEV=0.
2. AdES at mem_pc=0x8000_0204, delay slot, vaddr=0x1001_0003 -> code=5, exc_pc=0x8000_0200, bd=1, badvaddr_we=1, badvaddr=0x1001_0003.
3. Detect with bus_busy=1 for 5 cycles -> DRAIN 5 cycles with flush=1, then a single cp0_commit on the cycle after bus_busy falls.
4. Eret with epc=0x8000_1000, redir_ready held 0 for 3 cycles -> cp0_eret pulse, cp0_commit=0, redir_valid held 3+1 cycles with redir_pc=0x8000_1000, IDLE next cycle.
5. irq (IE=1, EXL=0, IM[2]=1, cause_ip[2]=1) together with RI flag -> code=0; repeat with EXL=1 and Ov only -> epc_we=0, code=12.
6. Assert rst low during REDIR -> all outputs 0 immediately; after release, a fresh Bp event is handled normally (code=9).

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer: prioritises MEM-stage events, drains the bus,
// commits exception state to CP0, then flushes and redirects IF. Optional counters: CP0_EXC_STAT_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | watching MEM stage for an interrupt or exception flag
// S_DRAIN  | event latched, waiting for outstanding bus traffic to end
// S_COMMIT | single-cycle cp0_commit / cp0_eret pulse, redirect target latched
// S_REDIR  | holding redirect to IF until redir_ready_i
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VEC_NORMAL = 32'h8000_0180,
    parameter logic [31:0] EXC_VEC_BOOT   = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_delay_slot_i,
    input  logic [31:0] mem_vaddr_i,
    input  logic [7:0]  exc_flags_i,
    input  logic [31:0] status_i,
    input  logic [7:0]  cause_ip_i,
    input  logic [31:0] epc_i,
    input  logic        bus_busy_i,
    output logic        cp0_commit_o,
    output logic        cp0_eret_o,
    output logic [4:0]  cp0_exc_code_o,
    output logic        cp0_epc_we_o,
    output logic [31:0] cp0_exc_pc_o,
    output logic        cp0_bd_o,
    output logic        cp0_badvaddr_we_o,
    output logic [31:0] cp0_badvaddr_o,
    output logic        flush_o,
    output logic        redir_valid_o,
    output logic [31:0] redir_pc_o,
    input  logic        redir_ready_i
`ifdef CP0_EXC_STAT_EN
    ,
    output logic [31:0] exc_count_o,
    output logic [31:0] eret_count_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_COMMIT = 2'd2,
        S_REDIR  = 2'd3
    } state_t;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    state_t      state_q, state_d;
    logic [4:0]  code_q, code_d;
    logic        eret_q, eret_d;
    logic [31:0] exc_pc_q, exc_pc_d;
    logic        bd_q, bd_d;
    logic        epc_we_q, epc_we_d;
    logic        bv_we_q, bv_we_d;
    logic [31:0] bv_q, bv_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic        irq;
    logic        detect;
    logic [4:0]  ev_code;
    logic        ev_eret;
    logic        ev_bv_we;
    logic [31:0] ev_bv;

    logic unused_status;
    assign unused_status = ^{status_i[31:23], status_i[21:16], status_i[7:2]};

    assign irq    = status_i[0] & ~status_i[1] & (|(cause_ip_i & status_i[15:8]));
    assign detect = (state_q == S_IDLE) & mem_valid_i & (irq | (|exc_flags_i));

    // Priority encoder; interrupts win over every synchronous exception.
    always_comb begin
        ev_code  = EXC_INT;
        ev_eret  = 1'b0;
        ev_bv_we = 1'b0;
        ev_bv    = 32'h0;
        if (irq) begin
            ev_code = EXC_INT;
        end else if (exc_flags_i[7]) begin
            ev_code  = EXC_ADEL;
            ev_bv_we = 1'b1;
            ev_bv    = mem_pc_i;
        end else if (exc_flags_i[6]) begin
            ev_code = EXC_RI;
        end else if (exc_flags_i[5]) begin
            ev_code = EXC_SYS;
        end else if (exc_flags_i[4]) begin
            ev_code = EXC_BP;
        end else if (exc_flags_i[3]) begin
            ev_eret = 1'b1;
        end else if (exc_flags_i[2]) begin
            ev_code = EXC_OV;
        end else if (exc_flags_i[1]) begin
            ev_code  = EXC_ADES;
            ev_bv_we = 1'b1;
            ev_bv    = mem_vaddr_i;
        end else if (exc_flags_i[0]) begin
            ev_code  = EXC_ADEL;
            ev_bv_we = 1'b1;
            ev_bv    = mem_vaddr_i;
        end
    end

    // Event record is captured only in the detect cycle; MEM inputs are ignored afterwards.
    always_comb begin
        code_d     = code_q;
        eret_d     = eret_q;
        exc_pc_d   = exc_pc_q;
        bd_d       = bd_q;
        epc_we_d   = epc_we_q;
        bv_we_d    = bv_we_q;
        bv_d       = bv_q;
        redir_pc_d = redir_pc_q;
        if (detect) begin
            code_d   = ev_code;
            eret_d   = ev_eret;
            exc_pc_d = mem_delay_slot_i ? (mem_pc_i - 32'd4) : mem_pc_i;
            bd_d     = mem_delay_slot_i;
            epc_we_d = ~status_i[1] & ~ev_eret;
            bv_we_d  = ev_bv_we;
            bv_d     = ev_bv;
        end
        // EPC is sampled late so an MTC0 EPC ahead of the eret is honoured.
        if (state_q == S_COMMIT) begin
            if (eret_q) begin
                redir_pc_d = epc_i;
            end else begin
                redir_pc_d = status_i[22] ? EXC_VEC_BOOT : EXC_VEC_NORMAL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            code_q     <= 5'd0;
            eret_q     <= 1'b0;
            exc_pc_q   <= 32'h0;
            bd_q       <= 1'b0;
            epc_we_q   <= 1'b0;
            bv_we_q    <= 1'b0;
            bv_q       <= 32'h0;
            redir_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            eret_q     <= eret_d;
            exc_pc_q   <= exc_pc_d;
            bd_q       <= bd_d;
            epc_we_q   <= epc_we_d;
            bv_we_q    <= bv_we_d;
            bv_q       <= bv_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cp0_commit_o  = 1'b0;
        cp0_eret_o    = 1'b0;
        flush_o       = 1'b0;
        redir_valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (detect) begin
                    state_d = bus_busy_i ? S_DRAIN : S_COMMIT;
                end
            end
            S_DRAIN: begin
                flush_o = 1'b1;
                if (!bus_busy_i) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                flush_o      = 1'b1;
                cp0_commit_o = ~eret_q;
                cp0_eret_o   = eret_q;
                state_d      = S_REDIR;
            end
            S_REDIR: begin
                flush_o       = 1'b1;
                redir_valid_o = 1'b1;
                if (redir_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cp0_exc_code_o    = code_q;
    assign cp0_epc_we_o      = epc_we_q;
    assign cp0_exc_pc_o      = exc_pc_q;
    assign cp0_bd_o          = bd_q;
    assign cp0_badvaddr_we_o = bv_we_q;
    assign cp0_badvaddr_o    = bv_q;
    assign redir_pc_o        = redir_pc_q;

`ifdef CP0_EXC_STAT_EN
    logic [31:0] exc_cnt_q, exc_cnt_d;
    logic [31:0] eret_cnt_q, eret_cnt_d;

    always_comb begin
        exc_cnt_d  = exc_cnt_q + {31'd0, cp0_commit_o};
        eret_cnt_d = eret_cnt_q + {31'd0, cp0_eret_o};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exc_cnt_q  <= 32'h0;
            eret_cnt_q <= 32'h0;
        end else begin
            exc_cnt_q  <= exc_cnt_d;
            eret_cnt_q <= eret_cnt_d;
        end
    end

    assign exc_count_o  = exc_cnt_q;
    assign eret_count_o = eret_cnt_q;
`endif

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: event model computed from the priority
// rules and timing schedule, checked every cycle while an event is in flight.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_ds, bus_busy, redir_ready;
    logic [31:0] mem_pc, mem_vaddr, status, epc;
    logic [7:0]  exc_flags, cause_ip;
    logic        cp0_commit, cp0_eret, cp0_epc_we, cp0_bd, cp0_bv_we, flush, redir_valid;
    logic [4:0]  cp0_code;
    logic [31:0] cp0_exc_pc, cp0_bv, redir_pc;
`ifdef CP0_EXC_STAT_EN
    logic [31:0] exc_count, eret_count;
`endif

    int total = 0;
    int bad   = 0;

    cp0_exc_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .mem_valid_i       (mem_valid),
        .mem_pc_i          (mem_pc),
        .mem_delay_slot_i  (mem_ds),
        .mem_vaddr_i       (mem_vaddr),
        .exc_flags_i       (exc_flags),
        .status_i          (status),
        .cause_ip_i        (cause_ip),
        .epc_i             (epc),
        .bus_busy_i        (bus_busy),
        .cp0_commit_o      (cp0_commit),
        .cp0_eret_o        (cp0_eret),
        .cp0_exc_code_o    (cp0_code),
        .cp0_epc_we_o      (cp0_epc_we),
        .cp0_exc_pc_o      (cp0_exc_pc),
        .cp0_bd_o          (cp0_bd),
        .cp0_badvaddr_we_o (cp0_bv_we),
        .cp0_badvaddr_o    (cp0_bv),
        .flush_o           (flush),
        .redir_valid_o     (redir_valid),
        .redir_pc_o        (redir_pc),
        .redir_ready_i     (redir_ready)
`ifdef CP0_EXC_STAT_EN
        ,
        .exc_count_o       (exc_count),
        .eret_count_o      (eret_count)
`endif
    );

    always #5 clk = ~clk;

    // expected event record and schedule
    logic [4:0]  e_code;
    logic        e_eret, e_bd, e_epc_we, e_bv_we;
    logic [31:0] e_exc_pc, e_bv, e_redir;
    int          e_busy, e_ready;
    int          k_cyc  = 0;
    logic        chk_en = 1'b0;

    // values observed at the commit pulse, pinned against literals
    logic [4:0]  last_code;
    logic [31:0] last_exc_pc, last_bv, last_redir;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".commit"}, {31'd0, cp0_commit}, 32'd0);
        chk({tag, ".eret"}, {31'd0, cp0_eret}, 32'd0);
        chk({tag, ".code"}, {27'd0, cp0_code}, 32'd0);
        chk({tag, ".epc_we"}, {31'd0, cp0_epc_we}, 32'd0);
        chk({tag, ".exc_pc"}, cp0_exc_pc, 32'd0);
        chk({tag, ".bd"}, {31'd0, cp0_bd}, 32'd0);
        chk({tag, ".bv_we"}, {31'd0, cp0_bv_we}, 32'd0);
        chk({tag, ".bv"}, cp0_bv, 32'd0);
        chk({tag, ".flush"}, {31'd0, flush}, 32'd0);
        chk({tag, ".redir_valid"}, {31'd0, redir_valid}, 32'd0);
        chk({tag, ".redir_pc"}, redir_pc, 32'd0);
    endtask

    // Expected outcome from the architectural rules.
    task automatic predict(input logic [7:0] fl, input logic [31:0] st, input logic [7:0] ip,
                           input logic [31:0] pc, input logic ds, input logic [31:0] va,
                           input logic [31:0] epc_cmt);
        int codes [8] = '{4, 5, 12, -1, 9, 8, 10, 4}; // indexed by flag bit
        logic irq_m;
        int   hit;
        irq_m = st[0] && !st[1] && ((ip & st[15:8]) != 8'd0);
        hit = -1;
        for (int b = 7; b >= 0; b--) begin
            if (hit < 0 && fl[b]) hit = b;
        end
        e_eret   = !irq_m && (hit == 3);
        e_code   = irq_m ? 5'd0 : (e_eret ? 5'd0 : 5'(codes[hit]));
        e_exc_pc = ds ? pc - 32'd4 : pc;
        e_bd     = ds;
        e_epc_we = !e_eret && !st[1];
        e_bv_we  = !irq_m && (hit == 7 || hit == 1 || hit == 0);
        e_bv     = (hit == 7) ? pc : va;
        e_redir  = e_eret ? epc_cmt : (st[22] ? 32'hBFC0_0380 : 32'h8000_0180);
    endtask

    task automatic clear_mem();
        mem_valid = 1'b0;
        exc_flags = 8'h00;
        mem_pc    = 32'h0;
        mem_vaddr = 32'h0;
        mem_ds    = 1'b0;
    endtask

    // One event: detect cycle, then busy_n DRAIN cycles, COMMIT, redirect held ready_n extra cycles.
    task automatic run_event(input logic [7:0] fl, input logic [31:0] st, input logic [7:0] ip,
                             input logic [31:0] pc, input logic ds, input logic [31:0] va,
                             input logic [31:0] epc_det, input logic [31:0] epc_cmt,
                             input int busy_n, input int ready_n);
        predict(fl, st, ip, pc, ds, va, epc_cmt);
        e_busy  = busy_n;
        e_ready = ready_n;
        @(posedge clk); #1;
        mem_valid = 1'b1; exc_flags = fl; status = st; cause_ip = ip;
        mem_pc = pc; mem_ds = ds; mem_vaddr = va; epc = epc_det;
        bus_busy = (busy_n > 0); redir_ready = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        for (int k = 1; k <= busy_n + 3 + ready_n; k++) begin
            #1;
            k_cyc       = k;
            bus_busy    = (k < busy_n);
            redir_ready = (k >= busy_n + 2 + ready_n);
            epc         = epc_cmt;
            if (k < busy_n + 3 + ready_n) begin
                mem_valid = 1'b1; exc_flags = 8'hFF; mem_pc = 32'hDEAD_BEE0;
                mem_vaddr = 32'h1234_5678; mem_ds = ~ds;
            end else begin
                clear_mem();
            end
            @(posedge clk);
        end
        chk_en = 1'b0;
        #1 redir_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("commit", {31'd0, cp0_commit}, {31'd0, (k_cyc == e_busy + 1) && !e_eret});
            chk("eret", {31'd0, cp0_eret}, {31'd0, (k_cyc == e_busy + 1) && e_eret});
            chk("flush", {31'd0, flush}, {31'd0, k_cyc <= e_busy + 2 + e_ready});
            chk("redir_valid", {31'd0, redir_valid},
                {31'd0, (k_cyc >= e_busy + 2) && (k_cyc <= e_busy + 2 + e_ready)});
            if (k_cyc == e_busy + 1) begin
                if (!e_eret) chk("code", {27'd0, cp0_code}, {27'd0, e_code});
                chk("exc_pc", cp0_exc_pc, e_exc_pc);
                chk("bd", {31'd0, cp0_bd}, {31'd0, e_bd});
                chk("epc_we", {31'd0, cp0_epc_we}, {31'd0, e_epc_we});
                chk("bv_we", {31'd0, cp0_bv_we}, {31'd0, e_bv_we});
                if (e_bv_we) chk("badvaddr", cp0_bv, e_bv);
                last_code   = cp0_code;
                last_exc_pc = cp0_exc_pc;
                last_bv     = cp0_bv;
            end
            if ((k_cyc >= e_busy + 2) && (k_cyc <= e_busy + 2 + e_ready)) begin
                chk("redir_pc", redir_pc, e_redir);
                last_redir = redir_pc;
            end
        end
    end

    initial begin
        rst = 1'b0;
        clear_mem();
        status = 32'h0; cause_ip = 8'h0; epc = 32'h0;
        bus_busy = 1'b0; redir_ready = 1'b0;
        #2 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // 1: Sys, bus idle, BEV=0
        run_event(8'h20, 32'h0, 8'h0, 32'hBFC0_0100, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);
        chk("t1.code", {27'd0, last_code}, 32'd8);
        chk("t1.exc_pc", last_exc_pc, 32'hBFC0_0100);
        chk("t1.redir", last_redir, 32'h8000_0180);

        // 2: AdES in delay slot
        run_event(8'h02, 32'h0, 8'h0, 32'h8000_0204, 1'b1, 32'h1001_0003, 32'h0, 32'h0, 0, 1);
        chk("t2.code", {27'd0, last_code}, 32'd5);
        chk("t2.exc_pc", last_exc_pc, 32'h8000_0200);
        chk("t2.bv", last_bv, 32'h1001_0003);

        // 3: bus busy for 5 cycles
        run_event(8'h20, 32'h0, 8'h0, 32'h8000_0040, 1'b0, 32'h0, 32'h0, 32'h0, 5, 0);

        // 4: Eret, EPC written late, ready withheld 3 cycles
        run_event(8'h08, 32'h0000_0002, 8'h0, 32'h8000_2000, 1'b0, 32'h0,
                  32'h1111_1110, 32'h8000_1000, 0, 3);
        chk("t4.redir", last_redir, 32'h8000_1000);

        // 5: interrupt beats RI; then EXL masks irq and Ov is taken without EPC update
        run_event(8'h40, 32'h0000_0401, 8'h04, 32'h8000_0300, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);
        chk("t5.code", {27'd0, last_code}, 32'd0);
        run_event(8'h04, 32'h0000_0403, 8'h04, 32'h8000_0310, 1'b0, 32'h0, 32'h0, 32'h0, 1, 0);
        chk("t5b.code", {27'd0, last_code}, 32'd12);

        // extra: AdEL-IF with BEV=1, AdEL-MEM with delay-slot wrap at PC 0
        run_event(8'h81, 32'h0040_0000, 8'h0, 32'h0000_0003, 1'b0, 32'h5555_0001, 32'h0, 32'h0, 2, 2);
        chk("t7.redir", last_redir, 32'hBFC0_0380);
        run_event(8'h01, 32'h0, 8'h0, 32'h0000_0000, 1'b1, 32'h0000_0101, 32'h0, 32'h0, 0, 0);
        chk("t8.exc_pc", last_exc_pc, 32'hFFFF_FFFC);

        // interrupt pending without a valid MEM instruction is not taken
        @(posedge clk); #1;
        mem_valid = 1'b0; status = 32'h0000_0401; cause_ip = 8'h04;
        repeat (3) begin
            @(negedge clk);
            chk("noirq.flush", {31'd0, flush}, 32'd0);
        end
        #1 status = 32'h0; cause_ip = 8'h0;

        // 6: reset during REDIR, then a fresh Bp
        @(posedge clk); #1;
        mem_valid = 1'b1; exc_flags = 8'h20; mem_pc = 32'h8000_0500;
        @(posedge clk); #1 clear_mem();
        @(posedge clk); #1;
        chk("t6.in_redir", {31'd0, redir_valid}, 32'd1);
        rst = 1'b0;
        #1 chk_all_zero("t6.reset");
        @(posedge clk); #1 rst = 1'b1;
        run_event(8'h10, 32'h0, 8'h0, 32'h8000_0600, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);
        chk("t6.code", {27'd0, last_code}, 32'd9);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
